rackbus_rx_word_assembler: RTL and testbench

Sits directly downstream of the rackbus clock-phase tracker in the rxclk domain. Consumes the once-per-syncclk phase pulse (one rxclk cycle in four) plus the 8-bit deserialized rackbus byte stream. Qualifies the pulse's periodicity with a hunt/check/locked state machine, then packs four bytes per syncclk period into one 32-bit word. Counts phase errors for status.

---
 rtl/rackbus_rx_word_assembler.sv | 97 +++++++++
 tb/tb_rackbus_rx_word_assembler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rackbus_rx_word_assembler.sv
// rackbus_rx_word_assembler: qualifies syncclk phase pulses and packs four rackbus bytes per period into 32-bit words
module rackbus_rx_word_assembler #(
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        rxclk,
  input  logic        rst_n,
  input  logic        sync_i,
  input  logic [7:0]  dat_i,
  input  logic        clr_err_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        locked_o,
  output logic        sync_err_o,
  output logic [15:0] err_count_o
);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  localparam logic [7:0] LC = 8'(LOCK_COUNT);
  localparam logic [3:0] UE = 4'(UNLOCK_ERRS);
  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d, ph;
  logic [7:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic [7:0]  b0_q, b1_q, b2_q;
  logic [31:0] word_q, word_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d, locked_q, err_q;
  logic        chk, good, err;
  always_comb begin
    chk     = state_q != HUNT;
    good    = chk && phase_q == 2'd0 && sync_i;
    err     = chk && ((phase_q == 2'd0) != sync_i);
    // only a pulse seen while hunting realigns the phase; misplaced pulses elsewhere are just errors
    ph      = (state_q == HUNT && sync_i) ? 2'd0 : phase_q;
    phase_d = ph + 2'd1;
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      HUNT: if (sync_i) begin
        state_d = CHECK;
        good_d  = '0;
      end
      CHECK: if (err) state_d = HUNT;
      else if (good) begin
        good_d = good_q + 8'd1;
        if (good_d == LC) begin
          state_d = LOCKED;
          bad_d   = '0;
        end
      end
      LOCKED: if (err) begin
        bad_d = bad_q + 4'd1;
        if (bad_d == UE) state_d = HUNT;
      end
      else if (good) bad_d = '0;
      default: state_d = HUNT;
    endcase
    valid_d = state_q == LOCKED && phase_q == 2'd3;
    word_d  = valid_d ? {b0_q, b1_q, b2_q, dat_i} : word_q;
    cnt_d   = clr_err_i ? '0 : (err && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      phase_q  <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      b0_q     <= ph == 2'd0 ? dat_i : b0_q;
      b1_q     <= ph == 2'd1 ? dat_i : b1_q;
      b2_q     <= ph == 2'd2 ? dat_i : b2_q;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      locked_q <= state_d == LOCKED;
      err_q    <= err;
    end
  end
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign sync_err_o   = err_q;
  assign err_count_o  = cnt_q;
endmodule

// File: tb/tb_rackbus_rx_word_assembler.sv
// tb_rackbus_rx_word_assembler: directed checks of lock qualification, word packing and error counting
module tb_rackbus_rx_word_assembler;
  logic        rxclk = 1'b0, rst_n = 1'b0, sync_i = 1'b0, clr_err_i = 1'b0;
  logic [7:0]  dat_i = '0;
  logic [31:0] word_o;
  logic        word_valid_o, locked_o, sync_err_o;
  logic [15:0] err_count_o;
  int checks = 0, errors = 0, cyc_n = 0, off = 0, ms = -1, me = -1, extra = -1;
  always #5 rxclk = ~rxclk;
  rackbus_rx_word_assembler dut (
    .rxclk(rxclk), .rst_n(rst_n), .sync_i(sync_i), .dat_i(dat_i), .clr_err_i(clr_err_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .locked_o(locked_o),
    .sync_err_o(sync_err_o), .err_count_o(err_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask
  task automatic tick(input logic s, input logic [7:0] d);
    sync_i = s;
    dat_i  = d;
    @(posedge rxclk);
    #1;
    cyc_n++;
  endtask
  // nominal pulse train every 4 cycles from off, minus the [ms,me) window, plus one extra pulse
  task automatic run_to(input int t);
    while (cyc_n < t)
      tick((((cyc_n - off) % 4 == 0) && !(cyc_n >= ms && cyc_n < me)) || cyc_n == extra, 8'(cyc_n));
  endtask
  task automatic sat_periods(input int n);
    repeat (4 * n) tick(1'b1, 8'(cyc_n));
  endtask
  initial begin
    @(posedge rxclk);
    #1;
    chk("rst_word", word_o, 32'h0);
    chk("rst_valid", 32'(word_valid_o), 32'h0);
    chk("rst_locked", 32'(locked_o), 32'h0);
    chk("rst_syncerr", 32'(sync_err_o), 32'h0);
    chk("rst_cnt", 32'(err_count_o), 32'h0);
    #3 rst_n = 1'b1;
    run_to(64);
    chk("pre_lock", 32'(locked_o), 32'h0);
    run_to(65);
    chk("lock_rise", 32'(locked_o), 32'h1);
    run_to(67);
    chk("no_strobe_67", 32'(word_valid_o), 32'h0);
    run_to(68);
    chk("first_valid", 32'(word_valid_o), 32'h1);
    chk("first_word", word_o, 32'h40414243);
    chk("cnt_clean", 32'(err_count_o), 32'h0);
    run_to(69);
    chk("valid_oneshot", 32'(word_valid_o), 32'h0);
    run_to(72);
    chk("second_word", word_o, 32'h44454647);
    ms = 80;
    me = 89;
    run_to(81);
    chk("miss1_err", 32'(sync_err_o), 32'h1);
    chk("miss1_cnt", 32'(err_count_o), 32'h1);
    run_to(82);
    chk("err_oneshot", 32'(sync_err_o), 32'h0);
    run_to(84);
    chk("miss_valid", 32'(word_valid_o), 32'h1);
    chk("miss_word", word_o, 32'h50515253);
    run_to(89);
    chk("miss3_err", 32'(sync_err_o), 32'h1);
    run_to(90);
    chk("miss3_cnt", 32'(err_count_o), 32'h3);
    chk("miss3_locked", 32'(locked_o), 32'h1);
    run_to(92);
    chk("resume_word", word_o, 32'h58595A5B);
    ms = 100;
    me = 113;
    run_to(112);
    chk("drop_pre_locked", 32'(locked_o), 32'h1);
    chk("drop_last_valid", 32'(word_valid_o), 32'h1);
    chk("drop_last_word", word_o, 32'h6C6D6E6F);
    chk("drop_pre_cnt", 32'(err_count_o), 32'h6);
    run_to(113);
    chk("drop_locked", 32'(locked_o), 32'h0);
    chk("drop_err", 32'(sync_err_o), 32'h1);
    chk("drop_cnt", 32'(err_count_o), 32'h7);
    chk("drop_valid", 32'(word_valid_o), 32'h0);
    run_to(116);
    chk("hunt_no_valid", 32'(word_valid_o), 32'h0);
    chk("hunt_word_hold", word_o, 32'h6C6D6E6F);
    run_to(180);
    chk("relock_pre", 32'(locked_o), 32'h0);
    run_to(181);
    chk("relock", 32'(locked_o), 32'h1);
    run_to(184);
    chk("relock_valid", 32'(word_valid_o), 32'h1);
    chk("relock_word", word_o, 32'hB4B5B6B7);
    chk("relock_cnt", 32'(err_count_o), 32'h7);
    run_to(186);
    #2 rst_n = 1'b0;
    #1;
    chk("async_word", word_o, 32'h0);
    chk("async_locked", 32'(locked_o), 32'h0);
    chk("async_cnt", 32'(err_count_o), 32'h0);
    #1 rst_n = 1'b1;
    cyc_n = 0;
    ms = -1;
    me = -1;
    extra = 22;
    run_to(4);
    chk("post_rst_valid", 32'(word_valid_o), 32'h0);
    run_to(23);
    chk("misplaced_err", 32'(sync_err_o), 32'h1);
    chk("misplaced_cnt", 32'(err_count_o), 32'h1);
    off = 2;
    ms = 24;
    me = 30;
    run_to(27);
    chk("hunt_quiet_err", 32'(sync_err_o), 32'h0);
    chk("hunt_quiet_cnt", 32'(err_count_o), 32'h1);
    run_to(94);
    chk("rs_prelock", 32'(locked_o), 32'h0);
    run_to(95);
    chk("rs_lock", 32'(locked_o), 32'h1);
    run_to(98);
    chk("rs_valid", 32'(word_valid_o), 32'h1);
    chk("rs_word", word_o, 32'h5E5F6061);
    run_to(102);
    sat_periods(1);
    chk("sat_start_cnt", 32'(err_count_o), 32'h4);
    chk("sat_start_lock", 32'(locked_o), 32'h1);
    sat_periods(21843);
    chk("sat_near", 32'(err_count_o), 32'hFFFD);
    sat_periods(3);
    chk("sat_hold", 32'(err_count_o), 32'hFFFF);
    chk("sat_locked", 32'(locked_o), 32'h1);
    chk("sat_err", 32'(sync_err_o), 32'h1);
    tick(1'b1, 8'(cyc_n));
    clr_err_i = 1'b1;
    tick(1'b1, 8'(cyc_n));
    clr_err_i = 1'b0;
    chk("clr_cnt", 32'(err_count_o), 32'h0);
    chk("clr_err_pulse", 32'(sync_err_o), 32'h1);
    tick(1'b0, 8'(cyc_n));
    chk("clr_after_cnt", 32'(err_count_o), 32'h0);
    chk("clr_after_err", 32'(sync_err_o), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
